// File: rtl/sj_pkg.sv
// Shared types for the main-bus arbiter: FSM state encoding and bus owner.
package sj_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2,
    ST_REL   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_Z80 = 1'b0,
    OWN_MCU = 1'b1
  } owner_t;
endpackage

// File: rtl/sj_edge_pulse.sv
// Registered one-clock pulse on each rising edge of a level input.
module sj_edge_pulse (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_pulse <= i_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/sj_bus_arbiter.sv
// Main-bus arbiter between the Z80 and the MCU (BUSRQ/BUSAK handshake), bus mux
// and comm-latch access decode producing bs_wr/bs_rd pulses.
module sj_bus_arbiter
  import sj_pkg::*;
#(
  parameter logic [15:0] COMM_ADDR = 16'hD404,
  parameter logic [7:0]  ACK_TMO   = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_cen,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_dout,
  output logic [7:0]  o_cpu_din,
  input  logic        i_cpu_mreq_n,
  input  logic        i_cpu_rd_n,
  input  logic        i_cpu_wr_n,
  output logic        o_cpu_busrq_n,
  input  logic        i_cpu_busak_n,
  input  logic        i_mcu_busrq_n,
  output logic        o_mcu_busak_n,
  input  logic [15:0] i_mcu_addr,
  input  logic [7:0]  i_mcu_dout,
  input  logic        i_mcu_we,
  input  logic        i_mcu_rd,
  output logic [7:0]  o_mcu_din,
  output logic        o_bs_wr,
  output logic        o_bs_rd,
  input  logic [7:0]  i_bs_din,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_dout,
  output logic        o_mem_we,
  output logic        o_mem_rd,
  input  logic [7:0]  i_mem_din,
  output logic        o_err_tmo
);
  state_t     r_state, w_state_nxt;
  logic       r_cpu_busrq_n, w_cpu_busrq_n_nxt;
  logic       r_mcu_busak_n, w_mcu_busak_n_nxt;
  logic [7:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic       r_err_tmo, w_err_tmo_nxt;
  logic [7:0] r_mcu_din;
  owner_t     w_owner;
  logic       w_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cpu_busrq_n <= 1'b1;
      r_mcu_busak_n <= 1'b1;
      r_tmo_cnt     <= 8'd0;
      r_err_tmo     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cpu_busrq_n <= w_cpu_busrq_n_nxt;
      r_mcu_busak_n <= w_mcu_busak_n_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_err_tmo     <= w_err_tmo_nxt;
    end
  end

  // Timeout is a down-counter loaded on request; it only moves on Z80 clock enables.
  always_comb begin
    w_state_nxt       = r_state;
    w_cpu_busrq_n_nxt = r_cpu_busrq_n;
    w_mcu_busak_n_nxt = r_mcu_busak_n;
    w_tmo_cnt_nxt     = r_tmo_cnt;
    w_err_tmo_nxt     = r_err_tmo;
    case (r_state)
      ST_IDLE: begin
        if (!i_mcu_busrq_n) begin
          w_state_nxt       = ST_REQ;
          w_cpu_busrq_n_nxt = 1'b0;
          w_tmo_cnt_nxt     = ACK_TMO;
        end
      end
      ST_REQ: begin
        if (!i_cpu_busak_n) begin
          w_state_nxt       = ST_GRANT;
          w_mcu_busak_n_nxt = 1'b0;
        end else if (i_mcu_busrq_n) begin
          w_state_nxt       = ST_REL;
          w_cpu_busrq_n_nxt = 1'b1;
        end else if (i_cpu_cen) begin
          if (r_tmo_cnt <= 8'd1) begin
            w_tmo_cnt_nxt = 8'd0;
            w_err_tmo_nxt = 1'b1;
          end else begin
            w_tmo_cnt_nxt = r_tmo_cnt - 8'd1;
          end
        end
      end
      ST_GRANT: begin
        if (i_mcu_busrq_n) begin
          w_state_nxt       = ST_REL;
          w_mcu_busak_n_nxt = 1'b1;
          w_cpu_busrq_n_nxt = 1'b1;
        end
      end
      ST_REL: begin
        w_cpu_busrq_n_nxt = 1'b1;
        if (i_cpu_busak_n) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_mcu_din <= 8'd0;
    else if (r_state == ST_GRANT && i_mcu_rd && !i_mcu_we)
      r_mcu_din <= i_mem_din;
  end

  assign w_owner = (r_state == ST_GRANT) ? OWN_MCU : OWN_Z80;
  assign w_hit   = (w_owner == OWN_Z80) && !i_cpu_mreq_n && (i_cpu_addr == COMM_ADDR);

  // A write strobe wins over a simultaneous MCU read.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_dout = i_cpu_dout;
    o_mem_we   = 1'b0;
    o_mem_rd   = 1'b0;
    if (w_owner == OWN_MCU) begin
      o_mem_addr = i_mcu_addr;
      o_mem_dout = i_mcu_dout;
      o_mem_we   = i_mcu_we;
      o_mem_rd   = i_mcu_rd & ~i_mcu_we;
    end else begin
      o_mem_we   = ~i_cpu_mreq_n & ~i_cpu_wr_n & ~w_hit;
      o_mem_rd   = ~i_cpu_mreq_n & ~i_cpu_rd_n & ~w_hit;
    end
  end

  sj_edge_pulse u_bs_wr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_level (w_hit & ~i_cpu_wr_n),
    .o_pulse (o_bs_wr)
  );

  sj_edge_pulse u_bs_rd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_level (w_hit & ~i_cpu_rd_n),
    .o_pulse (o_bs_rd)
  );

  assign o_cpu_din     = w_hit ? i_bs_din : i_mem_din;
  assign o_cpu_busrq_n = r_cpu_busrq_n;
  assign o_mcu_busak_n = r_mcu_busak_n;
  assign o_mcu_din     = r_mcu_din;
  assign o_err_tmo     = r_err_tmo;
endmodule

// File: tb/tb_sj_bus_arbiter.sv
// Directed bench for sj_bus_arbiter: reset, grant, MCU access, comm decode, timeout, async reset.
module tb_sj_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cen;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic        cpu_busrq_n, cpu_busak_n;
  logic        mcu_busrq_n, mcu_busak_n;
  logic [15:0] mcu_addr;
  logic [7:0]  mcu_dout;
  logic        mcu_we, mcu_rd;
  logic [7:0]  mcu_din;
  logic        bs_wr, bs_rd;
  logic [7:0]  bs_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we, mem_rd;
  logic [7:0]  mem_din;
  logic        err_tmo;

  int n_pass  = 0;
  int n_total = 0;
  int n_pulse;

  always #5 clk = ~clk;

  sj_bus_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_cen(cpu_cen),
    .i_cpu_addr(cpu_addr), .i_cpu_dout(cpu_dout), .o_cpu_din(cpu_din),
    .i_cpu_mreq_n(cpu_mreq_n), .i_cpu_rd_n(cpu_rd_n), .i_cpu_wr_n(cpu_wr_n),
    .o_cpu_busrq_n(cpu_busrq_n), .i_cpu_busak_n(cpu_busak_n),
    .i_mcu_busrq_n(mcu_busrq_n), .o_mcu_busak_n(mcu_busak_n),
    .i_mcu_addr(mcu_addr), .i_mcu_dout(mcu_dout), .i_mcu_we(mcu_we), .i_mcu_rd(mcu_rd),
    .o_mcu_din(mcu_din), .o_bs_wr(bs_wr), .o_bs_rd(bs_rd), .i_bs_din(bs_din),
    .o_mem_addr(mem_addr), .o_mem_dout(mem_dout), .o_mem_we(mem_we), .o_mem_rd(mem_rd),
    .i_mem_din(mem_din), .o_err_tmo(err_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; cpu_cen = 1'b1;
    cpu_addr = 16'h0000; cpu_dout = 8'h00;
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_busak_n = 1'b1;
    mcu_busrq_n = 1'b1; mcu_addr = 16'h0000; mcu_dout = 8'h00; mcu_we = 1'b0; mcu_rd = 1'b0;
    bs_din = 8'h00; mem_din = 8'h00;
    #12;
    // reset values
    check("rst_cpu_busrq_n", cpu_busrq_n, 1'b1);
    check("rst_mcu_busak_n", mcu_busak_n, 1'b1);
    check("rst_mcu_din", mcu_din, 8'h00);
    check("rst_err_tmo", err_tmo, 1'b0);
    check("rst_bs_wr", bs_wr, 1'b0);
    check("rst_bs_rd", bs_rd, 1'b0);
    rst = 1'b0;
    tick();

    // Z80 owns the bus after reset
    cpu_addr = 16'h1234; cpu_dout = 8'hAB; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    check("z80_mem_addr", mem_addr, 16'h1234);
    check("z80_mem_dout", mem_dout, 8'hAB);
    check("z80_mem_we", mem_we, 1'b1);
    check("z80_mem_rd_idle", mem_rd, 1'b0);
    cpu_wr_n = 1'b1; cpu_rd_n = 1'b0; mem_din = 8'h3C;
    #1;
    check("z80_mem_rd", mem_rd, 1'b1);
    check("z80_cpu_din", cpu_din, 8'h3C);
    cpu_rd_n = 1'b1; cpu_mreq_n = 1'b1;
    tick();

    // grant
    mcu_addr = 16'hC010; mcu_dout = 8'h5A;
    mcu_busrq_n = 1'b0;
    tick();
    check("req_cpu_busrq_n", cpu_busrq_n, 1'b0);
    check("req_mcu_busak_n", mcu_busak_n, 1'b1);
    check("req_mem_addr_z80", mem_addr, 16'h1234);
    tick(); tick(); tick();
    check("req_wait_busak", mcu_busak_n, 1'b1);
    cpu_busak_n = 1'b0;
    tick();
    check("grant_mcu_busak_n", mcu_busak_n, 1'b0);
    mcu_we = 1'b1;
    #1;
    check("mcu_mem_we", mem_we, 1'b1);
    check("mcu_mem_addr", mem_addr, 16'hC010);
    check("mcu_mem_dout", mem_dout, 8'h5A);
    mcu_we = 1'b0;
    // Z80 strobes on the comm address during GRANT are ignored
    cpu_addr = 16'hD404; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    check("grant_z80_mem_we", mem_we, 1'b0);
    n_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bs_wr) n_pulse++;
    end
    check("grant_no_bs_wr", n_pulse[3:0], 4'd0);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;

    // MCU read capture
    mcu_rd = 1'b1; mem_din = 8'hA3;
    #1;
    check("mcu_mem_rd", mem_rd, 1'b1);
    tick();
    check("mcu_din_a3", mcu_din, 8'hA3);
    mcu_we = 1'b1; mem_din = 8'h55;
    #1;
    check("both_mem_rd", mem_rd, 1'b0);
    tick();
    check("both_no_capture", mcu_din, 8'hA3);
    mcu_we = 1'b0; mcu_rd = 1'b0; mem_din = 8'h99;
    tick();
    check("mcu_din_hold", mcu_din, 8'hA3);

    // release; new request held off until IDLE
    mcu_busrq_n = 1'b1;
    tick();
    check("rel_mcu_busak_n", mcu_busak_n, 1'b1);
    check("rel_mem_addr_z80", mem_addr, 16'hD404);
    mcu_busrq_n = 1'b0;
    tick(); tick();
    check("rel_cpu_busrq_n", cpu_busrq_n, 1'b1);
    check("rel_no_regrant", mcu_busak_n, 1'b1);
    cpu_busak_n = 1'b1;
    tick();
    check("idle_cpu_busrq_n", cpu_busrq_n, 1'b1);
    tick();
    check("rereq_cpu_busrq_n", cpu_busrq_n, 1'b0);
    mcu_busrq_n = 1'b1;
    tick();
    check("withdraw_cpu_busrq_n", cpu_busrq_n, 1'b1);
    tick();
    check("withdraw_err_tmo", err_tmo, 1'b0);

    // comm latch write
    cpu_addr = 16'hD404; cpu_dout = 8'h11; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    check("comm_mem_we", mem_we, 1'b0);
    n_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bs_wr) n_pulse++;
    end
    check("comm_bs_wr_count", n_pulse[3:0], 4'd1);
    check("comm_bs_rd_quiet", bs_rd, 1'b0);
    cpu_wr_n = 1'b1;
    tick();
    // comm latch read
    bs_din = 8'h77; mem_din = 8'h3C; cpu_rd_n = 1'b0;
    #1;
    check("comm_cpu_din", cpu_din, 8'h77);
    check("comm_mem_rd", mem_rd, 1'b0);
    n_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bs_rd) n_pulse++;
    end
    check("comm_bs_rd_count", n_pulse[3:0], 4'd1);
    cpu_addr = 16'hD405;
    #1;
    check("near_cpu_din", cpu_din, 8'h3C);
    check("near_mem_rd", mem_rd, 1'b1);
    cpu_rd_n = 1'b1; cpu_mreq_n = 1'b1;
    tick();

    // timeout: 100 + 154 enabled ticks, 50 disabled in between, then the 255th
    mcu_busrq_n = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) tick();
    cpu_cen = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    cpu_cen = 1'b1;
    for (int i = 0; i < 154; i++) tick();
    check("tmo_254_ticks", err_tmo, 1'b0);
    tick();
    check("tmo_255_ticks", err_tmo, 1'b1);
    check("tmo_still_req", cpu_busrq_n, 1'b0);
    mcu_busrq_n = 1'b1;
    tick();
    check("tmo_rel_busrq_n", cpu_busrq_n, 1'b1);
    tick();
    check("tmo_sticky", err_tmo, 1'b1);
    check("tmo_idle_busak_n", mcu_busak_n, 1'b1);

    // async reset in GRANT
    mcu_busrq_n = 1'b0;
    tick();
    cpu_busak_n = 1'b0;
    tick();
    check("g2_mcu_busak_n", mcu_busak_n, 1'b0);
    check("g2_mem_addr_mcu", mem_addr, 16'hC010);
    #2 rst = 1'b1;
    #1;
    check("arst_mcu_busak_n", mcu_busak_n, 1'b1);
    check("arst_cpu_busrq_n", cpu_busrq_n, 1'b1);
    check("arst_err_tmo", err_tmo, 1'b0);
    check("arst_mem_addr_z80", mem_addr, 16'hD405);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
